// File: rtl/ntt_controller_if.sv
// rtl/ntt_controller_if.sv - control and RAM/ROM address bus of the NTT sequencer
interface ntt_controller_if #(
    parameter int log_n = 8
);
    localparam int stage_w = $clog2(log_n);

    logic               start;
    logic               mode;
    logic               busy;
    logic               done;
    logic               bf_select;
    logic [stage_w-1:0] stage;
    logic               rd_en;
    logic [log_n-1:0]   rd_addr_a;
    logic [log_n-1:0]   rd_addr_b;
    logic [log_n-1:0]   tw_addr;
    logic               wr_en;
    logic [log_n-1:0]   wr_addr_a;
    logic [log_n-1:0]   wr_addr_b;

    modport master (
        input  start, mode,
        output busy, done, bf_select, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, mode,
        input  busy, done, bf_select, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_controller.sv
// rtl/ntt_controller.sv - in-place radix-2 NTT/INTT sequencer, one butterfly per cycle
module ntt_controller #(
    parameter int log_n = 8,
    parameter int lat   = 2
) (
    input  logic              clk,
    input  logic              rst,
    ntt_controller_if.master  bus
);
    localparam int stage_w = $clog2(log_n);
    localparam int j_w     = log_n - 1;
    localparam int cnt_w   = $clog2(lat + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [stage_w-1:0] s_q;
    logic [j_w-1:0]     j_q;
    logic [cnt_w-1:0]   cnt_q;
    logic               mode_q;
    logic               busy_q;
    logic               done_q;
    logic               rd_en_q;
    logic [log_n-1:0]   ra_q;
    logic [log_n-1:0]   rb_q;
    logic [log_n-1:0]   tw_q;

    logic [lat-1:0]     wen_pipe;
    logic [log_n-1:0]   wa_pipe [lat];
    logic [log_n-1:0]   wb_pipe [lat];

    // Packs {tw, b, a} for butterfly j of stage s; NTT spans shrink, INTT spans grow.
    function automatic logic [3*log_n-1:0] pair_addr(input int s_i, input int j_i, input logic md);
        int k;
        int g;
        int o;
        int a;
        int b;
        int tw;
        k  = md ? s_i : (log_n - 1 - s_i);
        g  = j_i >> k;
        o  = j_i & ((1 << k) - 1);
        a  = (g << (k + 1)) | o;
        b  = a + (1 << k);
        tw = (1 << (log_n - 1 - k)) + g;
        return {tw[log_n-1:0], b[log_n-1:0], a[log_n-1:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        s_q     <= '0;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        {tw_q, rb_q, ra_q} <= pair_addr(0, 0, bus.mode);
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (&j_q) begin
                        rd_en_q <= 1'b0;
                        cnt_q   <= cnt_w'(lat);
                        state   <= DRAIN;
                    end else begin
                        j_q <= j_q + j_w'(1);
                        {tw_q, rb_q, ra_q} <= pair_addr(int'(s_q), int'(j_q) + 1, mode_q);
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q - cnt_w'(1);
                    // The final write of this stage lands at the end of this cycle.
                    if (cnt_q == cnt_w'(1)) begin
                        if (s_q == stage_w'(log_n - 1)) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            s_q     <= s_q + stage_w'(1);
                            j_q     <= '0;
                            rd_en_q <= 1'b1;
                            {tw_q, rb_q, ra_q} <= pair_addr(int'(s_q) + 1, 0, mode_q);
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back mirrors the read pair exactly lat cycles later; reset drops in-flight writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_pipe <= '0;
            for (int i = 0; i < lat; i++) begin
                wa_pipe[i] <= '0;
                wb_pipe[i] <= '0;
            end
        end else begin
            for (int i = lat - 1; i > 0; i--) begin
                wen_pipe[i] <= wen_pipe[i-1];
                wa_pipe[i]  <= wa_pipe[i-1];
                wb_pipe[i]  <= wb_pipe[i-1];
            end
            wen_pipe[0] <= rd_en_q;
            wa_pipe[0]  <= ra_q;
            wb_pipe[0]  <= rb_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bf_select = mode_q;
    assign bus.stage     = s_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = ra_q;
    assign bus.rd_addr_b = rb_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_en     = wen_pipe[lat-1];
    assign bus.wr_addr_a = wa_pipe[lat-1];
    assign bus.wr_addr_b = wb_pipe[lat-1];
endmodule

// File: tb/tb_ntt_controller.sv
// tb/tb_ntt_controller.sv - directed bench for ntt_controller with N=8, lat=2, q=17
module tb_ntt_controller;
    localparam int log_n = 3;
    localparam int lat   = 2;
    localparam int n_pts = 8;
    localparam int q     = 17;

    localparam int ntt_a[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    localparam int ntt_b[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    localparam int ntt_tw[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
    localparam int int_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    localparam int int_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    localparam int int_tw[12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};
    // omega = 2 is a primitive 8th root of unity mod 17; ROM holds heap-ordered twiddles and inverses.
    localparam int rom_fwd[8] = '{0, 1, 1, 4, 1, 4, 2, 8};
    localparam int rom_inv[8] = '{0, 1, 1, 13, 1, 13, 9, 15};
    localparam int pw[8]      = '{1, 2, 4, 8, 16, 15, 13, 9};
    localparam int brv[8]     = '{0, 4, 2, 6, 1, 5, 3, 7};
    localparam int n_inv      = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_controller_if #(.log_n(log_n)) bus ();
    ntt_controller #(.log_n(log_n), .lat(lat)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic       cap_rd [64];
    logic       cap_wr [64];
    logic       cap_busy [64];
    logic       cap_done [64];
    logic       cap_bf [64];
    logic [1:0] cap_stage [64];
    logic [2:0] cap_ra [64];
    logic [2:0] cap_rb [64];
    logic [2:0] cap_tw [64];
    logic [2:0] cap_wa [64];
    logic [2:0] cap_wb [64];

    int   ram [n_pts];
    int   x_in [n_pts];
    int   pq [$];
    logic model_on = 1'b0;

    function automatic int mod_q(input int v);
        return ((v % q) + q) % q;
    endfunction

    always @(negedge clk) begin
        int a;
        int b;
        int w;
        int t;
        if (model_on) begin
            if (bus.wr_en && pq.size() >= 2) begin
                ram[bus.wr_addr_a] = pq.pop_front();
                ram[bus.wr_addr_b] = pq.pop_front();
            end
            if (bus.rd_en) begin
                a = ram[bus.rd_addr_a];
                b = ram[bus.rd_addr_b];
                w = bus.bf_select ? rom_inv[bus.tw_addr] : rom_fwd[bus.tw_addr];
                if (!bus.bf_select) begin
                    t = mod_q(b * w);
                    pq.push_back(mod_q(a + t));
                    pq.push_back(mod_q(a - t));
                end else begin
                    pq.push_back(mod_q(a + b));
                    pq.push_back(mod_q((a - b) * w));
                end
            end
        end
    end

    task automatic capture(input logic md, input logic toggle, input int ncyc);
        @(negedge clk);
        bus.mode  = md;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (toggle) bus.mode = ~bus.mode;
            cap_rd[k]    = bus.rd_en;
            cap_wr[k]    = bus.wr_en;
            cap_busy[k]  = bus.busy;
            cap_done[k]  = bus.done;
            cap_bf[k]    = bus.bf_select;
            cap_stage[k] = bus.stage;
            cap_ra[k]    = bus.rd_addr_a;
            cap_rb[k]    = bus.rd_addr_b;
            cap_tw[k]    = bus.tw_addr;
            cap_wa[k]    = bus.wr_addr_a;
            cap_wb[k]    = bus.wr_addr_b;
        end
        bus.mode = 1'b0;
    endtask

    task automatic check_run(input logic md, input string tag);
        for (int k = 1; k <= 20; k++) begin
            int   pos;
            int   idx;
            int   kk;
            int   widx;
            logic e_rd;
            logic e_wr;
            pos  = (k - 1) % 6;
            idx  = ((k - 1) / 6) * 4 + pos;
            e_rd = (k <= 18) && (pos < 4);
            checks++;
            if (cap_rd[k] !== e_rd) begin
                errors++;
                $display("FAIL %s rd_en cycle %0d got %0b exp %0b", tag, k, cap_rd[k], e_rd);
            end
            if (e_rd) begin
                checks++;
                if (cap_ra[k] !== 3'(md ? int_a[idx] : ntt_a[idx]) ||
                    cap_rb[k] !== 3'(md ? int_b[idx] : ntt_b[idx]) ||
                    cap_tw[k] !== 3'(md ? int_tw[idx] : ntt_tw[idx]) ||
                    cap_stage[k] !== 2'((k - 1) / 6)) begin
                    errors++;
                    $display("FAIL %s rd pair cycle %0d got a=%0d b=%0d tw=%0d st=%0d exp a=%0d b=%0d tw=%0d st=%0d",
                             tag, k, cap_ra[k], cap_rb[k], cap_tw[k], cap_stage[k],
                             md ? int_a[idx] : ntt_a[idx], md ? int_b[idx] : ntt_b[idx],
                             md ? int_tw[idx] : ntt_tw[idx], (k - 1) / 6);
                end
            end
            kk   = k - lat;
            widx = ((kk - 1) / 6) * 4 + (kk - 1) % 6;
            e_wr = (kk >= 1) && (kk <= 18) && ((kk - 1) % 6 < 4);
            checks++;
            if (cap_wr[k] !== e_wr) begin
                errors++;
                $display("FAIL %s wr_en cycle %0d got %0b exp %0b", tag, k, cap_wr[k], e_wr);
            end
            if (e_wr) begin
                checks++;
                if (cap_wa[k] !== 3'(md ? int_a[widx] : ntt_a[widx]) ||
                    cap_wb[k] !== 3'(md ? int_b[widx] : ntt_b[widx])) begin
                    errors++;
                    $display("FAIL %s wr pair cycle %0d got a=%0d b=%0d exp a=%0d b=%0d", tag, k,
                             cap_wa[k], cap_wb[k], md ? int_a[widx] : ntt_a[widx], md ? int_b[widx] : ntt_b[widx]);
                end
            end
            checks++;
            if (cap_busy[k] !== (k <= 18) || cap_done[k] !== (k == 19)) begin
                errors++;
                $display("FAIL %s busy/done cycle %0d got %0b/%0b exp %0b/%0b", tag, k,
                         cap_busy[k], cap_done[k], k <= 18, k == 19);
            end
            if (k <= 19) begin
                checks++;
                if (cap_bf[k] !== md) begin
                    errors++;
                    $display("FAIL %s bf_select cycle %0d got %0b exp %0b", tag, k, cap_bf[k], md);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.bf_select} !== 5'b0 ||
            bus.stage !== 2'd0 || bus.rd_addr_a !== 3'd0 || bus.rd_addr_b !== 3'd0 ||
            bus.tw_addr !== 3'd0 || bus.wr_addr_a !== 3'd0 || bus.wr_addr_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%0b done=%0b rd=%0b wr=%0b st=%0d exp all zero",
                     bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.stage);
        end
        rst = 1'b0;
    endtask

    task automatic test_ntt_addresses();
        capture(1'b0, 1'b0, 20);
        check_run(1'b0, "ntt");
    endtask

    task automatic test_intt_mode_toggle();
        capture(1'b1, 1'b1, 20);
        check_run(1'b1, "intt_toggle");
    endtask

    task automatic test_back_to_back();
        int pulses [$];
        int waited;
        @(negedge clk);
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (bus.done) pulses.push_back(k);
        end
        bus.start = 1'b0;
        checks++;
        if (pulses.size() != 3) begin
            errors++;
            $display("FAIL b2b pulse_count got %0d exp 3", pulses.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < pulses.size()) begin
                checks++;
                if (pulses[i] != 19 + 20 * i) begin
                    errors++;
                    $display("FAIL b2b done_cycle %0d got %0d exp %0d", i, pulses[i], 19 + 20 * i);
                end
            end
        end
        waited = 0;
        while (!bus.done && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL b2b drain_timeout got done=0 exp done=1");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic late;
        @(negedge clk);
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (bus.stage !== 2'd1 || bus.rd_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst precondition got st=%0d rd=%0b exp st=1 rd=1", bus.stage, bus.rd_en);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.stage !== 2'd0 ||
            bus.done !== 1'b0 || bus.rd_addr_a !== 3'd0 || bus.wr_addr_b !== 3'd0) begin
            errors++;
            $display("FAIL midrst outputs got busy=%0b rd=%0b wr=%0b st=%0d exp 0 0 0 0",
                     bus.busy, bus.rd_en, bus.wr_en, bus.stage);
        end
        rst  = 1'b0;
        late = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.wr_en || bus.rd_en || bus.busy) late = 1'b1;
        end
        checks++;
        if (late) begin
            errors++;
            $display("FAIL midrst late_activity got 1 exp 0");
        end
    endtask

    task automatic run_model(input logic md, output int done_at);
        pq.delete();
        model_on = 1'b1;
        done_at  = -1;
        @(negedge clk);
        bus.mode  = md;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) done_at = k;
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        model_on = 1'b0;
    endtask

    task automatic test_model();
        int done_at;
        int acc;
        for (int i = 0; i < n_pts; i++) begin
            x_in[i] = $urandom_range(0, q - 1);
            ram[i]  = x_in[i];
        end
        run_model(1'b0, done_at);
        checks++;
        if (done_at != 19) begin
            errors++;
            $display("FAIL model ntt_done_cycle got %0d exp 19", done_at);
        end
        for (int p = 0; p < n_pts; p++) begin
            acc = 0;
            for (int n = 0; n < n_pts; n++) acc = mod_q(acc + x_in[n] * pw[(n * brv[p]) % n_pts]);
            checks++;
            if (ram[p] != acc) begin
                errors++;
                $display("FAIL model ntt_out[%0d] got %0d exp %0d", p, ram[p], acc);
            end
        end
        run_model(1'b1, done_at);
        checks++;
        if (done_at != 19) begin
            errors++;
            $display("FAIL model intt_done_cycle got %0d exp 19", done_at);
        end
        for (int i = 0; i < n_pts; i++) begin
            checks++;
            if (mod_q(ram[i] * n_inv) != x_in[i]) begin
                errors++;
                $display("FAIL model intt_out[%0d] got %0d exp %0d", i, mod_q(ram[i] * n_inv), x_in[i]);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        test_reset();
        test_ntt_addresses();
        repeat (2) @(negedge clk);
        test_intt_mode_toggle();
        repeat (2) @(negedge clk);
        test_back_to_back();
        test_reset_mid_run();
        test_model();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
